// File: rtl/exe_stage_pkg.sv
// Shared widths, bus layouts, op bit indices and store lane alignment for the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD   = 156;
  localparam int ES_TO_MS_BUS_WD   = 78;
  localparam int ES_FWD_BLK_BUS_WD = 39;

  localparam int ALU_ADD = 11, ALU_SUB = 10, ALU_SLT = 9, ALU_SLTU = 8, ALU_AND = 7, ALU_NOR = 6;
  localparam int ALU_OR  = 5,  ALU_XOR = 4,  ALU_SLL = 3, ALU_SRL  = 2, ALU_SRA = 1, ALU_LUI = 0;
  localparam int HL_MULT = 7, HL_MULTU = 6, HL_DIV = 5, HL_DIVU = 4;
  localparam int HL_MTHI = 3, HL_MTLO  = 2, HL_MFHI = 1, HL_MFLO = 0;
  localparam int ST_SB = 4, ST_SH = 3, ST_SW = 2, ST_SWL = 1, ST_SWR = 0;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [6:0]  ld;
    logic [4:0]  st;
    logic [7:0]  hl;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_zimm;
    logic        src2_is_8;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  // Returns {wen, wdata}; unaligned swl/swr place the partial word in the addressed lanes.
  function automatic logic [35:0] store_align(input logic [4:0] st, input logic [1:0] a,
                                              input logic [31:0] rt);
    logic [3:0]  wen;
    logic [31:0] wdata;
    wen   = 4'b0000;
    wdata = 32'h0;
    if (st[ST_SB]) begin
      wen   = 4'b0001 << a;
      wdata = {4{rt[7:0]}};
    end else if (st[ST_SH]) begin
      wen   = a[1] ? 4'b1100 : 4'b0011;
      wdata = {2{rt[15:0]}};
    end else if (st[ST_SW]) begin
      wen   = 4'b1111;
      wdata = rt;
    end else if (st[ST_SWL]) begin
      case (a)
        2'd0:    begin wen = 4'b0001; wdata = {24'b0, rt[31:24]}; end
        2'd1:    begin wen = 4'b0011; wdata = {16'b0, rt[31:16]}; end
        2'd2:    begin wen = 4'b0111; wdata = {8'b0, rt[31:8]};   end
        default: begin wen = 4'b1111; wdata = rt;                 end
      endcase
    end else if (st[ST_SWR]) begin
      case (a)
        2'd0:    begin wen = 4'b1111; wdata = rt;                 end
        2'd1:    begin wen = 4'b1110; wdata = {rt[23:0], 8'b0};   end
        2'd2:    begin wen = 4'b1100; wdata = {rt[15:0], 16'b0};  end
        default: begin wen = 4'b1000; wdata = {rt[7:0], 24'b0};   end
      endcase
    end
    return {wen, wdata};
  endfunction

endpackage

// File: rtl/exe_stage_div.sv
// div_iter: 32-step restoring divider on magnitudes with final sign fix; result held until ack.
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic        ack,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  div_state_t  state, state_nxt;
  logic [4:0]  iter_p0;
  logic [31:0] quo_p0, rem_p0, dvs_p0;
  logic        neg_q_p0, neg_r_p0;
  logic [32:0] part;
  logic        ge;
  logic [31:0] part_sub;

  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = DIV_RUN;
      DIV_RUN:  if (iter_p0 == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: if (ack) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state != DIV_RUN) iter_p0 <= 5'd0;
    else                           iter_p0 <= iter_p0 + 5'd1;
  end

  // Partial remainder stays below the divisor, so the difference fits in 32 bits.
  assign part     = {rem_p0, quo_p0[31]};
  assign ge       = part >= {1'b0, dvs_p0};
  assign part_sub = part[31:0] - dvs_p0;

  // setup on start / one restoring iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (state == DIV_IDLE && start) begin
      quo_p0   <= (sign && x[31]) ? -x : x;
      dvs_p0   <= (sign && y[31]) ? -y : y;
      rem_p0   <= 32'h0;
      neg_q_p0 <= sign & (x[31] ^ y[31]);
      neg_r_p0 <= sign & x[31];
    end else if (state == DIV_RUN) begin
      rem_p0 <= ge ? part_sub : part[31:0];
      quo_p0 <= {quo_p0[30:0], ge};
    end
  end

  assign busy = (state == DIV_RUN);
  assign done = (state == DIV_DONE);
  assign q    = neg_q_p0 ? -quo_p0 : quo_p0;
  assign r    = neg_r_p0 ? -rem_p0 : rem_p0;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, HI/LO ops, address generation, data SRAM request, forward bus.
// Define MYCPU_DIV_EN to build the multi-cycle DIV/DIVU path; otherwise DIV/DIVU retire as NOPs.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ms_allowin,
  output logic                         es_allowin,
  input  logic                         ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0]   ds_to_es_bus,
  output logic                         es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  output logic [ES_FWD_BLK_BUS_WD-1:0] es_fwd_blk_bus,
  output logic                         data_sram_en,
  output logic [3:0]                   data_sram_wen,
  output logic [31:0]                  data_sram_addr,
  output logic [31:0]                  data_sram_wdata
);

  ds_to_es_t          es_p0;
  logic               es_valid, es_ready_go, commit;
  logic [31:0]        hi, lo;
  logic [31:0]        imm_sext, src1, src2, alu_res, vaddr, exe_result;
  logic signed [31:0] src1_s, src2_s;
  logic [63:0]        prod_s, prod_u;
  logic               is_div, is_mem, gr_we_eff;
  logic [3:0]         st_wen;
  logic [31:0]        st_wdata;

  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign commit         = es_valid && es_ready_go && ms_allowin;

  // stage register: decode -> execute
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
      es_p0    <= '0;
    end else begin
      if (es_allowin)                   es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) es_p0    <= ds_to_es_t'(ds_to_es_bus);
    end
  end

  assign is_div    = es_p0.hl[HL_DIV] | es_p0.hl[HL_DIVU];
  assign is_mem    = (|es_p0.ld) | (|es_p0.st);
  assign gr_we_eff = es_p0.gr_we & !is_div;
  assign imm_sext  = {{16{es_p0.imm[15]}}, es_p0.imm};
  assign src1      = es_p0.src1_is_sa  ? {27'b0, es_p0.imm[10:6]} :
                     es_p0.src1_is_pc  ? es_p0.pc : es_p0.rs;
  assign src2      = es_p0.src2_is_imm  ? imm_sext :
                     es_p0.src2_is_zimm ? {16'b0, es_p0.imm} :
                     es_p0.src2_is_8    ? 32'd8 : es_p0.rt;
  assign src1_s    = src1;
  assign src2_s    = src2;

  always_comb begin
    alu_res = 32'h0;
    if (es_p0.alu_op[ALU_ADD])  alu_res = alu_res | (src1 + src2);
    if (es_p0.alu_op[ALU_SUB])  alu_res = alu_res | (src1 - src2);
    if (es_p0.alu_op[ALU_SLT])  alu_res = alu_res | {31'b0, src1_s < src2_s};
    if (es_p0.alu_op[ALU_SLTU]) alu_res = alu_res | {31'b0, src1 < src2};
    if (es_p0.alu_op[ALU_AND])  alu_res = alu_res | (src1 & src2);
    if (es_p0.alu_op[ALU_NOR])  alu_res = alu_res | ~(src1 | src2);
    if (es_p0.alu_op[ALU_OR])   alu_res = alu_res | (src1 | src2);
    if (es_p0.alu_op[ALU_XOR])  alu_res = alu_res | (src1 ^ src2);
    if (es_p0.alu_op[ALU_SLL])  alu_res = alu_res | (src2 << src1[4:0]);
    if (es_p0.alu_op[ALU_SRL])  alu_res = alu_res | (src2 >> src1[4:0]);
    if (es_p0.alu_op[ALU_SRA])  alu_res = alu_res | 32'(src2_s >>> src1[4:0]);
    if (es_p0.alu_op[ALU_LUI])  alu_res = alu_res | {es_p0.imm, 16'b0};
  end

  assign vaddr      = es_p0.rs + imm_sext;
  assign exe_result = es_p0.hl[HL_MFHI] ? hi :
                      es_p0.hl[HL_MFLO] ? lo :
                      is_mem            ? vaddr : alu_res;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{es_p0.rs[31]}}, es_p0.rs} * {{32{es_p0.rt[31]}}, es_p0.rt};
  assign prod_u = {32'b0, es_p0.rs} * {32'b0, es_p0.rt};

`ifdef MYCPU_DIV_EN
  logic        div_busy, div_done;
  logic [31:0] div_q, div_r;

  div_iter u_div (
    .clk   (clk),
    .reset (reset),
    .start (es_valid && is_div && !div_done && !div_busy),
    .sign  (es_p0.hl[HL_DIV]),
    .ack   (commit),
    .x     (es_p0.rs),
    .y     (es_p0.rt),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );

  assign es_ready_go = !is_div || div_done;
`else
  assign es_ready_go = 1'b1;
`endif

  // HI/LO change only on commit, so a stalled instruction never writes twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end else if (commit) begin
      if      (es_p0.hl[HL_MULT])  {hi, lo} <= prod_s;
      else if (es_p0.hl[HL_MULTU]) {hi, lo} <= prod_u;
      else if (es_p0.hl[HL_MTHI])  hi <= es_p0.rs;
      else if (es_p0.hl[HL_MTLO])  lo <= es_p0.rs;
`ifdef MYCPU_DIV_EN
      else if (is_div) begin
        hi <= div_r;
        lo <= div_q;
      end
`endif
    end
  end

  assign {st_wen, st_wdata} = store_align(es_p0.st, vaddr[1:0], es_p0.rt);
  assign data_sram_en       = commit && is_mem;
  assign data_sram_wen      = data_sram_en ? st_wen : 4'b0000;
  assign data_sram_wdata    = st_wdata;
  assign data_sram_addr     = {vaddr[31:2], 2'b00};

  assign es_to_ms_bus   = {es_p0.ld, es_p0.res_from_mem, gr_we_eff, es_p0.dest, exe_result, es_p0.pc};
  assign es_fwd_blk_bus = {es_valid & es_p0.res_from_mem,
                           es_valid & gr_we_eff & !es_p0.res_from_mem,
                           es_valid ? es_p0.dest : 5'd0,
                           exe_result};

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an instruction-level MIPS model with HI/LO state.
`timescale 1ns/1ps
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin, es_allowin, ds_to_es_valid, es_to_ms_valid;
  logic [155:0] ds_to_es_bus;
  logic [77:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_blk_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_fwd_blk_bus  (es_fwd_blk_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

`ifdef MYCPU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam int DIV_WAIT = 33;

  localparam int OP_ADDU = 0, OP_ADDIU = 1, OP_SUBU = 2, OP_SLT = 3, OP_SLTU = 4, OP_AND = 5;
  localparam int OP_NOR = 6, OP_ORI = 7, OP_XOR = 8, OP_SLL = 9, OP_SRL = 10, OP_SRAV = 11;
  localparam int OP_LUI = 12, OP_LINK = 13, OP_MULT = 14, OP_MULTU = 15, OP_DIV = 16, OP_DIVU = 17;
  localparam int OP_MTHI = 18, OP_MTLO = 19, OP_MFHI = 20, OP_MFLO = 21, OP_LD = 22, OP_ST = 23;

  typedef struct packed {
    logic [11:0] alu; logic [6:0] ld; logic [4:0] st; logic [7:0] hl;
    logic s1sa, s1pc, s2imm, s2zimm, s28, rfm, gwe;
    logic [4:0] dest; logic [15:0] imm; logic [31:0] rs, rt, pc;
  } dsb_t;

  typedef struct {
    int op; int sub; int stall; int rst_at;
    logic [31:0] rs, rt, pc; logic [15:0] imm; logic [4:0] dest;
  } item_t;

  item_t       pending[$];
  item_t       slot;
  bit          slot_v, offered;
  int          wait_cnt, stall_left, cycles;
  logic [31:0] m_hi, m_lo;
  int          n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [155:0] encode(input item_t it);
    dsb_t b;
    b = '0;
    b.dest = it.dest; b.imm = it.imm; b.rs = it.rs; b.rt = it.rt; b.pc = it.pc; b.gwe = 1'b1;
    case (it.op)
      OP_ADDU:  b.alu[11] = 1'b1;
      OP_ADDIU: begin b.alu[11] = 1'b1; b.s2imm = 1'b1; end
      OP_SUBU:  b.alu[10] = 1'b1;
      OP_SLT:   b.alu[9] = 1'b1;
      OP_SLTU:  b.alu[8] = 1'b1;
      OP_AND:   b.alu[7] = 1'b1;
      OP_NOR:   b.alu[6] = 1'b1;
      OP_ORI:   begin b.alu[5] = 1'b1; b.s2zimm = 1'b1; end
      OP_XOR:   b.alu[4] = 1'b1;
      OP_SLL:   begin b.alu[3] = 1'b1; b.s1sa = 1'b1; end
      OP_SRL:   begin b.alu[2] = 1'b1; b.s1sa = 1'b1; end
      OP_SRAV:  b.alu[1] = 1'b1;
      OP_LUI:   begin b.alu[0] = 1'b1; b.s2imm = 1'b1; end
      OP_LINK:  begin b.alu[11] = 1'b1; b.s1pc = 1'b1; b.s28 = 1'b1; end
      OP_MULT:  begin b.hl[7] = 1'b1; b.gwe = 1'b0; end
      OP_MULTU: begin b.hl[6] = 1'b1; b.gwe = 1'b0; end
      OP_DIV:   begin b.hl[5] = 1'b1; b.gwe = !DIV_ON; end
      OP_DIVU:  begin b.hl[4] = 1'b1; b.gwe = !DIV_ON; end
      OP_MTHI:  begin b.hl[3] = 1'b1; b.gwe = 1'b0; end
      OP_MTLO:  begin b.hl[2] = 1'b1; b.gwe = 1'b0; end
      OP_MFHI:  b.hl[1] = 1'b1;
      OP_MFLO:  b.hl[0] = 1'b1;
      OP_LD:    begin b.ld[6-it.sub] = 1'b1; b.rfm = 1'b1; b.alu[11] = 1'b1; b.s2imm = 1'b1; end
      default:  begin b.st[4-it.sub] = 1'b1; b.gwe = 1'b0; b.alu[11] = 1'b1; b.s2imm = 1'b1; end
    endcase
    return b;
  endfunction

  function automatic bit has_res(input item_t it);
    return !(it.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO});
  endfunction

  function automatic bit exp_gwe(input item_t it);
    return (it.op <= OP_LINK) || it.op == OP_MFHI || it.op == OP_MFLO || it.op == OP_LD;
  endfunction

  // Architectural result of the instruction as a MIPS programmer sees it.
  function automatic logic [31:0] exp_res(input item_t it);
    logic [31:0] se;
    se = {{16{it.imm[15]}}, it.imm};
    case (it.op)
      OP_ADDU:  return it.rs + it.rt;
      OP_ADDIU: return it.rs + se;
      OP_SUBU:  return it.rs - it.rt;
      OP_SLT:   return ($signed(it.rs) < $signed(it.rt)) ? 32'd1 : 32'd0;
      OP_SLTU:  return (it.rs < it.rt) ? 32'd1 : 32'd0;
      OP_AND:   return it.rs & it.rt;
      OP_NOR:   return ~(it.rs | it.rt);
      OP_ORI:   return it.rs | {16'h0, it.imm};
      OP_XOR:   return it.rs ^ it.rt;
      OP_SLL:   return it.rt << it.imm[10:6];
      OP_SRL:   return it.rt >> it.imm[10:6];
      OP_SRAV:  return 32'($signed(it.rt) >>> it.rs[4:0]);
      OP_LUI:   return {it.imm, 16'h0};
      OP_LINK:  return it.pc + 32'd8;
      OP_MFHI:  return m_hi;
      OP_MFLO:  return m_lo;
      default:  return it.rs + se;
    endcase
  endfunction

  task automatic exp_store(input int sub, input logic [1:0] a, input logic [31:0] rt,
                           output logic [3:0] wen, output logic [31:0] wd);
    int sh;
    sh = 3 - int'(a);
    case (sub)
      0: begin wen = 4'b0001 << a; wd = {4{rt[7:0]}}; end
      1: begin wen = 4'b0011 << (2 * int'(a[1])); wd = {2{rt[15:0]}}; end
      2: begin wen = 4'hF; wd = rt; end
      3: begin wen = 4'hF >> sh; wd = rt >> (8 * sh); end
      default: begin wen = 4'hF << a; wd = rt << (8 * int'(a)); end
    endcase
  endtask

  task automatic retire(input item_t it);
    logic [63:0] p;
    case (it.op)
      OP_MULT:  begin p = 64'(longint'($signed(it.rs)) * longint'($signed(it.rt))); {m_hi, m_lo} = p; end
      OP_MULTU: begin p = {32'h0, it.rs} * {32'h0, it.rt}; {m_hi, m_lo} = p; end
      OP_MTHI:  m_hi = it.rs;
      OP_MTLO:  m_lo = it.rs;
      OP_DIV:   if (DIV_ON) begin
                  m_lo = 32'($signed(it.rs) / $signed(it.rt));
                  m_hi = 32'($signed(it.rs) % $signed(it.rt));
                end
      OP_DIVU:  if (DIV_ON) begin m_lo = it.rs / it.rt; m_hi = it.rs % it.rt; end
      default: ;
    endcase
  endtask

  task automatic step();
    bit rst_now, is_dv, ready, commit, accept, mem;
    logic [3:0] wen; logic [31:0] wd, vaddr; logic [6:0] ldv;
    @(negedge clk);
    rst_now = slot_v && slot.rst_at != 0 && wait_cnt == slot.rst_at;
    reset = rst_now;
    ms_allowin = (slot_v && stall_left > 0) ? 1'b0 : ($urandom_range(3) != 0);
    if (!offered && pending.size() > 0 && $urandom_range(4) != 0) offered = 1'b1;
    ds_to_es_valid = offered && !rst_now;
    if (offered) ds_to_es_bus = encode(pending[0]);
    #1;
    is_dv  = slot_v && DIV_ON && (slot.op == OP_DIV || slot.op == OP_DIVU);
    ready  = !is_dv || wait_cnt >= DIV_WAIT;
    commit = slot_v && ready && ms_allowin;
    mem    = slot.op == OP_LD || slot.op == OP_ST;
    if (!rst_now) begin
      chk("es_to_ms_valid", es_to_ms_valid, slot_v && ready);
      chk("es_allowin", es_allowin, !slot_v || (ready && ms_allowin));
      chk("sram_en", data_sram_en, commit && mem);
      chk("load_blk", es_fwd_blk_bus[38], slot_v && slot.op == OP_LD);
      chk("fwd_valid", es_fwd_blk_bus[37], slot_v && exp_gwe(slot) && slot.op != OP_LD);
      chk("fwd_dest", es_fwd_blk_bus[36:32], slot_v ? slot.dest : 5'd0);
      if (slot_v && es_fwd_blk_bus[37]) chk("fwd_result", es_fwd_blk_bus[31:0], exp_res(slot));
      if (slot_v && es_to_ms_valid) begin
        ldv = (slot.op == OP_LD) ? (7'd1 << (6 - slot.sub)) : 7'd0;
        chk("bus_ld", es_to_ms_bus[77:71], ldv);
        chk("bus_rfm", es_to_ms_bus[70], slot.op == OP_LD);
        chk("bus_gwe", es_to_ms_bus[69], exp_gwe(slot));
        chk("bus_dest", es_to_ms_bus[68:64], slot.dest);
        if (has_res(slot)) chk("bus_result", es_to_ms_bus[63:32], exp_res(slot));
        chk("bus_pc", es_to_ms_bus[31:0], slot.pc);
      end
      if (commit && mem) begin
        vaddr = exp_res(slot);
        chk("sram_addr", data_sram_addr, {vaddr[31:2], 2'b00});
        if (slot.op == OP_ST) begin
          exp_store(slot.sub, vaddr[1:0], slot.rt, wen, wd);
          chk("sram_wen", data_sram_wen, wen);
          chk("sram_wdata", data_sram_wdata, wd);
        end else chk("sram_wen_load", data_sram_wen, 4'b0000);
      end
    end
    accept = offered && !rst_now && (!slot_v || commit);
    if (rst_now) begin
      slot_v = 1'b0; m_hi = 32'h0; m_lo = 32'h0; wait_cnt = 0; stall_left = 0;
    end else begin
      if (commit) retire(slot);
      if (slot_v && stall_left > 0) stall_left--;
      if (slot_v && !ready) wait_cnt++;
      if (commit) slot_v = 1'b0;
      if (accept) begin
        slot = pending.pop_front(); slot_v = 1'b1; offered = 1'b0;
        wait_cnt = 0; stall_left = slot.stall;
      end
    end
    cycles++;
    if (cycles > 60000) begin
      $display("FAIL cycle_budget: got %0d cycles, expected at most 60000", cycles);
      $fatal(1);
    end
  endtask

  function automatic item_t mk(input int op, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] imm, input int sub);
    item_t it;
    it.op = op; it.rs = rs; it.rt = rt; it.imm = imm; it.sub = sub;
    it.pc = {$urandom(), 2'b00} & 32'hFFFF_FFFC; it.dest = 5'($urandom_range(1, 31));
    it.stall = 0; it.rst_at = 0;
    return it;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    item_t it;
    n_chk = 0; n_pass = 0; cycles = 0; slot_v = 1'b0; offered = 1'b0;
    wait_cnt = 0; stall_left = 0; m_hi = 32'h0; m_lo = 32'h0;
    reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_es_to_ms_valid", es_to_ms_valid, 1'b0);
    chk("rst_es_allowin", es_allowin, 1'b1);
    chk("rst_sram_en", data_sram_en, 1'b0);
    chk("rst_fwd_bus", es_fwd_blk_bus, 39'h0);
    chk("rst_ms_bus", es_to_ms_bus, 78'h0);

    it = mk(OP_DIV, 32'd1000, 32'd3, 16'h0, 0); it.rst_at = 10; pending.push_back(it);
    pending.push_back(mk(OP_MFHI, 32'h0, 32'h0, 16'h0, 0));
    pending.push_back(mk(OP_MFLO, 32'h0, 32'h0, 16'h0, 0));
    pending.push_back(mk(OP_DIVU, 32'd100, 32'd7, 16'h0, 0));
    pending.push_back(mk(OP_MFLO, 32'h0, 32'h0, 16'h0, 0));
    pending.push_back(mk(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 16'h0, 0));
    pending.push_back(mk(OP_ST, 32'h1000_0000, 32'hAABB_CCDD, 16'h0001, 3));
    pending.push_back(mk(OP_DIV, 32'hFFFF_FFF9, 32'h2, 16'h0, 0));
    pending.push_back(mk(OP_MFLO, 32'h0, 32'h0, 16'h0, 0));
    pending.push_back(mk(OP_MFHI, 32'h0, 32'h0, 16'h0, 0));
    it = mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 0); it.stall = 5; pending.push_back(it);
    pending.push_back(mk(OP_MFHI, 32'h0, 32'h0, 16'h0, 0));
    pending.push_back(mk(OP_MFLO, 32'h0, 32'h0, 16'h0, 0));
    pending.push_back(mk(OP_LD, 32'h2000_0000, 32'h0, 16'h0010, 4));
    pending.push_back(mk(OP_DIV, 32'h8000_0000, 32'h7, 16'h0, 0));
    pending.push_back(mk(OP_DIV, 32'h0000_0009, 32'hFFFF_FFFC, 16'h0, 0));
    pending.push_back(mk(OP_MFHI, 32'h0, 32'h0, 16'h0, 0));

    for (int i = 0; i < 160; i++) begin
      it = mk($urandom_range(0, 23), pick(), pick(), 16'($urandom()), $urandom_range(0, 6));
      if (it.op == OP_ST) it.sub = it.sub % 5;
      if (it.op == OP_DIV || it.op == OP_DIVU) begin
        if (it.rt == 32'h0) it.rt = 32'd1;
        if (it.op == OP_DIV && it.rs == 32'h8000_0000 && it.rt == 32'hFFFF_FFFF) it.rt = 32'd3;
      end
      if ($urandom_range(7) == 0) it.stall = $urandom_range(1, 4);
      pending.push_back(it);
      if ((it.op == OP_DIV || it.op == OP_DIVU || it.op == OP_MULT) && $urandom_range(1) == 1)
        pending.push_back(mk(OP_MFLO + $urandom_range(0, 1) * (OP_MFHI - OP_MFLO), 32'h0, 32'h0, 16'h0, 0));
    end

    while (pending.size() > 0 || slot_v) step();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
